ex2_mem1_skid_stage: RTL and testbench
======================================

EX2_MEM1_SKID_STAGE -- requirements
Module: ex2_mem1_skid_stage

Interface
REQ-001 SHALL have parameter IMMEDIATE_WIDTH, default 16, immediate field width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, data/address width; SHALL be at least IMMEDIATE_WIDTH.
REQ-003 SHALL have parameter REG_INDEX_BITS, default 5, destination register index width.
REQ-004 SHALL have parameter THREAD_INDEX_BITS, default 3, thread index width.
REQ-005 Ports, in this order:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  EX2 beat present.
- in_ready  output  1  stage can accept a beat.
- in_increment_flag, in_load_word_flag, in_store_word_flag  input  1 each  op flags.
- in_immediate  input  IMMEDIATE_WIDTH  signed offset.
- in_thread_index  input  THREAD_INDEX_BITS  issuing thread.
- in_reg_index  input  REG_INDEX_BITS  destination register.
- in_data  input  DATA_WIDTH  operand/base address.
- out_valid  output  1  MEM1 beat present.
- out_ready  input  1  MEM1 can accept.
- out_increment_flag, out_load_word_flag, out_store_word_flag  output  1 each.
- out_immediate, out_thread_index, out_reg_index, out_data  output  matching widths.
- in_flush  input  1  flush request (flush build only).
- in_flush_thread  input  THREAD_INDEX_BITS  thread to flush (flush build only).

Function
REQ-006 SHALL be a 2-entry skid buffer (head, skid). Outputs SHALL always show the head entry.
REQ-007 Occupancy states: EMPTY, ONE, FULL. out_valid SHALL be 1 in ONE and FULL. in_ready SHALL be a registered signal, 1 unless FULL.
REQ-008 Input transfer SHALL occur on in_valid & in_ready. Output transfer SHALL occur on out_valid & out_ready.
REQ-009 EMPTY with push SHALL go to ONE. The beat SHALL appear on the outputs the next cycle (latency 1).
REQ-010 ONE transitions:
- push only SHALL go to FULL, with the beat stored in skid.
- pop only SHALL go to EMPTY.
- push+pop SHALL stay in ONE, with the incoming beat written to head.
REQ-011 FULL transitions: pop SHALL move skid to head and go to ONE. A push cannot occur because in_ready is 0.
REQ-012 Captured out_data SHALL be in_data plus in_immediate sign-extended to DATA_WIDTH when in_increment_flag=1, modulo 2^DATA_WIDTH (wraps, no carry out). Otherwise it SHALL be in_data unchanged.
REQ-013 All other fields SHALL be captured unmodified. Flag combinations SHALL be passed through without checking.
REQ-014 Beat order SHALL be preserved. No beat SHALL be duplicated or lost except by flush.
REQ-015 Entry contents SHALL be held stable while out_valid=1 and out_ready=0.

Reset
REQ-016 While reset_n=0, asynchronously: state SHALL be EMPTY; out_valid, in_ready and all three out flags SHALL be 0.
REQ-017 During reset, out_immediate, out_thread_index, out_reg_index and out_data SHALL also be 0.
REQ-018 Beats buffered when reset is asserted SHALL be discarded. in_ready SHALL become 1 on the first rising clk edge after reset_n deasserts.

Configuration
REQ-019 Macro EX2_MEM1_THREAD_FLUSH_EN SHALL control the flush feature.
REQ-020 When EX2_MEM1_THREAD_FLUSH_EN is defined, an edge with in_flush=1 SHALL:
- invalidate every held entry whose thread index equals in_flush_thread;
- drop an input transfer on that edge with the same thread;
- move a surviving skid entry into head.
REQ-021 In a flush, an output transfer completing on the same edge SHALL count as delivered. Flush applies only to the entries that remain after it.
REQ-022 When EX2_MEM1_THREAD_FLUSH_EN is undefined, in_flush and in_flush_thread SHALL be absent from the port list and no flush logic SHALL exist.

Verification
REQ-023 Reset then single beat: in_data=0x100, imm=0x0010, incr=1, out_ready=1. Required: out_valid one cycle later with out_data=0x110, then EMPTY.
REQ-024 Negative immediate: in_data=0x5, imm=0xFFFE, incr=1 -> out_data=0x3. Wrap case: in_data=0xFFFF_FFFF_FFFF_FFFF, imm=0x0001 -> out_data=0.
REQ-025 Backpressure: out_ready=0 with three beats offered (A,B,C). Required: A and B held, in_ready=0 after B, C stalls. Then raise out_ready: output order A,B,C, one per cycle.
REQ-026 Flush build: FULL with head thread 2 and skid thread 5, in_flush=1, in_flush_thread=2, out_ready=0. Required: next cycle ONE with the thread-5 beat on the outputs and in_ready=1.
REQ-027 Assert reset_n=0 mid-cycle while FULL. Required: out_valid and in_ready drop immediately without a clk edge; all outputs read 0.

Source files
------------

// File: rtl/ex2_mem1_skid_stage.sv
// EX2->MEM1 two-entry skid buffer with optional address increment on capture.
// Optional per-thread flush is enabled by defining EX2_MEM1_THREAD_FLUSH_EN.
module ex2_mem1_skid_stage #(
   parameter int IMMEDIATE_WIDTH   = 16,
   parameter int DATA_WIDTH        = 64,
   parameter int REG_INDEX_BITS    = 5,
   parameter int THREAD_INDEX_BITS = 3
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_increment_flag,
   input  logic                         in_load_word_flag,
   input  logic                         in_store_word_flag,
   input  logic [IMMEDIATE_WIDTH-1:0]   in_immediate,
   input  logic [THREAD_INDEX_BITS-1:0] in_thread_index,
   input  logic [REG_INDEX_BITS-1:0]    in_reg_index,
   input  logic [DATA_WIDTH-1:0]        in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_increment_flag,
   output logic                         out_load_word_flag,
   output logic                         out_store_word_flag,
   output logic [IMMEDIATE_WIDTH-1:0]   out_immediate,
   output logic [THREAD_INDEX_BITS-1:0] out_thread_index,
   output logic [REG_INDEX_BITS-1:0]    out_reg_index,
   output logic [DATA_WIDTH-1:0]        out_data
`ifdef EX2_MEM1_THREAD_FLUSH_EN
   ,
   input  logic                         in_flush,
   input  logic [THREAD_INDEX_BITS-1:0] in_flush_thread
`endif
);

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_ONE,
      ST_FULL
   } state_t;

   typedef struct packed {
      logic                         incr;
      logic                         load;
      logic                         store;
      logic [IMMEDIATE_WIDTH-1:0]   imm;
      logic [THREAD_INDEX_BITS-1:0] thread;
      logic [REG_INDEX_BITS-1:0]    regIdx;
      logic [DATA_WIDTH-1:0]        data;
   } entry_t;

   state_t r_state;
   entry_t r_head;
   entry_t r_skid;
   logic   r_inReady;
   logic   r_outValid;

   logic                  w_push;
   logic                  w_pop;
   logic [DATA_WIDTH-1:0] w_immExt;
   entry_t                w_inEntry;
   logic                  w_keepHead;
   logic                  w_keepSkid;
   logic                  w_keepIn;
   logic [1:0]            w_count;
   entry_t                w_nextHead;
   entry_t                w_nextSkid;
   state_t                w_nextState;

   assign w_push   = in_valid & r_inReady;
   assign w_pop    = r_outValid & out_ready;
   assign w_immExt = DATA_WIDTH'($signed(in_immediate));

   // The address add happens on capture so MEM1 sees a final address.
   always_comb begin
      w_inEntry        = '0;
      w_inEntry.incr   = in_increment_flag;
      w_inEntry.load   = in_load_word_flag;
      w_inEntry.store  = in_store_word_flag;
      w_inEntry.imm    = in_immediate;
      w_inEntry.thread = in_thread_index;
      w_inEntry.regIdx = in_reg_index;
      w_inEntry.data   = in_increment_flag ? (in_data + w_immExt) : in_data;
   end

   // Survivors in age order: head, skid, incoming; popped head is already delivered.
   always_comb begin
      w_keepHead = (r_state != ST_EMPTY) && !w_pop;
      w_keepSkid = (r_state == ST_FULL);
      w_keepIn   = w_push;
`ifdef EX2_MEM1_THREAD_FLUSH_EN
      if (in_flush) begin
         if (r_head.thread == in_flush_thread)
            w_keepHead = 1'b0;
         if (r_skid.thread == in_flush_thread)
            w_keepSkid = 1'b0;
         if (in_thread_index == in_flush_thread)
            w_keepIn = 1'b0;
      end
`endif
   end

   always_comb begin
      w_nextHead = r_head;
      w_nextSkid = r_skid;
      w_count    = {1'b0, w_keepHead} + {1'b0, w_keepSkid} + {1'b0, w_keepIn};
      if (w_keepHead) begin
         if (w_keepSkid)
            w_nextSkid = r_skid;
         else if (w_keepIn)
            w_nextSkid = w_inEntry;
      end else if (w_keepSkid) begin
         w_nextHead = r_skid;
         if (w_keepIn)
            w_nextSkid = w_inEntry;
      end else if (w_keepIn) begin
         w_nextHead = w_inEntry;
      end
      case (w_count)
         2'd0:    w_nextState = ST_EMPTY;
         2'd1:    w_nextState = ST_ONE;
         default: w_nextState = ST_FULL;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_EMPTY;
         r_head     <= '0;
         r_skid     <= '0;
         r_inReady  <= 1'b0;
         r_outValid <= 1'b0;
      end else begin
         r_state    <= w_nextState;
         r_head     <= w_nextHead;
         r_skid     <= w_nextSkid;
         r_inReady  <= (w_nextState != ST_FULL);
         r_outValid <= (w_nextState != ST_EMPTY);
      end
   end

   assign in_ready            = r_inReady;
   assign out_valid           = r_outValid;
   assign out_increment_flag  = r_head.incr;
   assign out_load_word_flag  = r_head.load;
   assign out_store_word_flag = r_head.store;
   assign out_immediate       = r_head.imm;
   assign out_thread_index    = r_head.thread;
   assign out_reg_index       = r_head.regIdx;
   assign out_data            = r_head.data;

endmodule

// File: tb/tb_ex2_mem1_skid_stage.sv
// Directed bench for ex2_mem1_skid_stage with a queue-based reference model
// checked every cycle; flush cases compile in when EX2_MEM1_THREAD_FLUSH_EN is set.
module tb_ex2_mem1_skid_stage;

   localparam int IW = 16;
   localparam int DW = 64;
   localparam int RW = 5;
   localparam int TW = 3;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          in_valid;
   logic          in_ready;
   logic          in_increment_flag;
   logic          in_load_word_flag;
   logic          in_store_word_flag;
   logic [IW-1:0] in_immediate;
   logic [TW-1:0] in_thread_index;
   logic [RW-1:0] in_reg_index;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_increment_flag;
   logic          out_load_word_flag;
   logic          out_store_word_flag;
   logic [IW-1:0] out_immediate;
   logic [TW-1:0] out_thread_index;
   logic [RW-1:0] out_reg_index;
   logic [DW-1:0] out_data;
`ifdef EX2_MEM1_THREAD_FLUSH_EN
   logic          in_flush;
   logic [TW-1:0] in_flush_thread;
`endif

   always #5 clk = ~clk;

   ex2_mem1_skid_stage #(
      .IMMEDIATE_WIDTH(IW), .DATA_WIDTH(DW), .REG_INDEX_BITS(RW), .THREAD_INDEX_BITS(TW)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_increment_flag(in_increment_flag), .in_load_word_flag(in_load_word_flag),
      .in_store_word_flag(in_store_word_flag), .in_immediate(in_immediate),
      .in_thread_index(in_thread_index), .in_reg_index(in_reg_index), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_increment_flag(out_increment_flag), .out_load_word_flag(out_load_word_flag),
      .out_store_word_flag(out_store_word_flag), .out_immediate(out_immediate),
      .out_thread_index(out_thread_index), .out_reg_index(out_reg_index), .out_data(out_data)
`ifdef EX2_MEM1_THREAD_FLUSH_EN
      , .in_flush(in_flush), .in_flush_thread(in_flush_thread)
`endif
   );

   typedef struct {
      logic          incr;
      logic          ld;
      logic          st;
      logic [IW-1:0] imm;
      logic [TW-1:0] thr;
      logic [RW-1:0] rg;
      logic [DW-1:0] data;
   } beat_t;

   beat_t q[$];
   logic  mReady = 1'b0;
   int    nChecks = 0;
   int    nPass = 0;

   task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
      nChecks++;
      if (actual === expected)
         nPass++;
      else
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
   endtask

   // Effective address rule: signed offset added modulo 2^64 when incrementing.
   function automatic logic [DW-1:0] expectedData(input logic incr, input logic [IW-1:0] imm, input logic [DW-1:0] d);
      longint off;
      off = longint'($signed(imm));
      return incr ? (d + DW'(off)) : d;
   endfunction

   always @(negedge reset_n) begin
      q.delete();
      mReady = 1'b0;
   end

   // Reference model: FIFO of at most two beats, then a compare one unit after the edge.
   always begin
      bit    push;
      bit    pop;
      beat_t b;
      @(posedge clk);
      if (reset_n) begin
         push   = in_valid && mReady;
         pop    = (q.size() > 0) && out_ready;
         b.incr = in_increment_flag;
         b.ld   = in_load_word_flag;
         b.st   = in_store_word_flag;
         b.imm  = in_immediate;
         b.thr  = in_thread_index;
         b.rg   = in_reg_index;
         b.data = expectedData(in_increment_flag, in_immediate, in_data);
         if (pop)
            q.delete(0);
`ifdef EX2_MEM1_THREAD_FLUSH_EN
         if (in_flush) begin
            for (int i = q.size() - 1; i >= 0; i--)
               if (q[i].thr == in_flush_thread)
                  q.delete(i);
            if (push && in_thread_index == in_flush_thread)
               push = 1'b0;
         end
`endif
         if (push)
            q.push_back(b);
         mReady = (q.size() < 2);
      end
      #1;
      checkOutput("out_valid", DW'(out_valid), DW'(q.size() != 0));
      checkOutput("in_ready", DW'(in_ready), DW'(mReady));
      if (q.size() != 0) begin
         checkOutput("out_data", out_data, q[0].data);
         checkOutput("out_immediate", DW'(out_immediate), DW'(q[0].imm));
         checkOutput("out_thread", DW'(out_thread_index), DW'(q[0].thr));
         checkOutput("out_reg", DW'(out_reg_index), DW'(q[0].rg));
         checkOutput("out_flags", DW'({out_increment_flag, out_load_word_flag, out_store_word_flag}),
                     DW'({q[0].incr, q[0].ld, q[0].st}));
      end
   end

   task automatic applyStimulus(input logic v, input logic incr, input logic ld, input logic st,
                                input logic [IW-1:0] imm, input logic [TW-1:0] thr,
                                input logic [RW-1:0] rg, input logic [DW-1:0] data, input logic oRdy);
      @(negedge clk);
      in_valid           = v;
      in_increment_flag  = incr;
      in_load_word_flag  = ld;
      in_store_word_flag = st;
      in_immediate       = imm;
      in_thread_index    = thr;
      in_reg_index       = rg;
      in_data            = data;
      out_ready          = oRdy;
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input logic oRdy);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, oRdy);
   endtask

   logic [DW-1:0] streamData[6] = '{64'h10, 64'h20, 64'h30, 64'h40, 64'h50, 64'h60};
   logic [IW-1:0] streamImm[6]  = '{16'h0001, 16'hFFFF, 16'h0100, 16'h8000, 16'h7FFF, 16'h0002};
   logic          readyPat[12]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

   initial begin
      int idx;
      reset_n = 1'b0;
      in_valid = 1'b0; in_increment_flag = 1'b0; in_load_word_flag = 1'b0; in_store_word_flag = 1'b0;
      in_immediate = '0; in_thread_index = '0; in_reg_index = '0; in_data = '0; out_ready = 1'b0;
`ifdef EX2_MEM1_THREAD_FLUSH_EN
      in_flush = 1'b0; in_flush_thread = '0;
`endif
      #1;
      checkOutput("reset out_valid", DW'(out_valid), 64'h0);
      checkOutput("reset in_ready", DW'(in_ready), 64'h0);
      checkOutput("reset out_data", out_data, 64'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      #1;
      checkOutput("in_ready before first edge", DW'(in_ready), 64'h0);
      @(posedge clk);
      #2;
      checkOutput("in_ready after first edge", DW'(in_ready), 64'h1);

      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 3'd1, 5'd3, 64'h100, 1'b1);
      checkOutput("single beat valid", DW'(out_valid), 64'h1);
      checkOutput("single beat data", out_data, 64'h110);
      idle(1'b1);
      checkOutput("single beat drained", DW'(out_valid), 64'h0);

      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFE, 3'd2, 5'd4, 64'h5, 1'b1);
      checkOutput("negative imm", out_data, 64'h3);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 3'd3, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      checkOutput("wrap", out_data, 64'h0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 16'h8000, 3'd4, 5'd31, 64'h1234, 1'b1);
      checkOutput("no incr data", out_data, 64'h1234);
      checkOutput("flags passthrough", DW'({out_increment_flag, out_load_word_flag, out_store_word_flag}), 64'h3);
      idle(1'b1);

      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0007, 3'd1, 5'd1, 64'h1000, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h0004, 3'd2, 5'd2, 64'h2000, 1'b0);
      checkOutput("bp in_ready after B", DW'(in_ready), 64'h0);
      checkOutput("bp head A", out_data, 64'h1000);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0009, 3'd3, 5'd3, 64'h3000, 1'b0);
      checkOutput("bp C stalls, A held", out_data, 64'h1000);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0009, 3'd3, 5'd3, 64'h3000, 1'b1);
      checkOutput("bp order B", out_data, 64'h2004);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0009, 3'd3, 5'd3, 64'h3000, 1'b1);
      checkOutput("bp order C", out_data, 64'h3000);
      idle(1'b1);
      checkOutput("bp drained", DW'(out_valid), 64'h0);

      idx = 0;
      for (int c = 0; c < 12; c++) begin
         logic acc;
         acc = (idx < 6) && mReady;
         if (idx < 6)
            applyStimulus(1'b1, 1'(idx % 2), 1'(idx % 3 == 0), 1'b0, streamImm[idx], 3'(idx),
                          5'(idx + 10), streamData[idx], readyPat[c]);
         else
            idle(readyPat[c]);
         if (acc)
            idx++;
      end
      repeat (3) idle(1'b1);
      checkOutput("stream all accepted", DW'(idx), 64'd6);

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 3'd6, 5'd6, 64'hAAAA, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 3'd7, 5'd7, 64'hBBBB, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async reset out_valid", DW'(out_valid), 64'h0);
      checkOutput("async reset in_ready", DW'(in_ready), 64'h0);
      checkOutput("async reset out_data", out_data, 64'h0);
      checkOutput("async reset fields", DW'({out_increment_flag, out_load_word_flag, out_store_word_flag,
                  out_immediate, out_thread_index, out_reg_index}), 64'h0);
      @(negedge clk);
      reset_n = 1'b1;
      idle(1'b1);
      checkOutput("after reset empty", DW'(out_valid), 64'h0);

`ifdef EX2_MEM1_THREAD_FLUSH_EN
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 3'd2, 5'd1, 64'hA0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 3'd5, 5'd2, 64'hB0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      in_flush = 1'b1;
      in_flush_thread = 3'd2;
      @(posedge clk);
      #2;
      checkOutput("flush valid", DW'(out_valid), 64'h1);
      checkOutput("flush survivor thread", DW'(out_thread_index), 64'h5);
      checkOutput("flush survivor data", out_data, 64'hB0);
      checkOutput("flush in_ready", DW'(in_ready), 64'h1);
      @(negedge clk);
      in_flush = 1'b0;
      repeat (2) idle(1'b1);
`endif

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
